jtriders_hdrcfg: RTL and testbench
==================================

JTRIDERS_HDRCFG -- requirements
Module: jtriders_hdrcfg

Interface
REQ-001 SHALL have parameter HDR_BYTES, default 16: header length in bytes, power of two, minimum 4.
REQ-002 SHALL have parameter NGAMES, default 3: number of supported game variants, 1..8.
REQ-003 SHALL have parameter IDW, default 3: game-id width.
REQ-004 SHALL have parameter ALLOW, default all NGAMES bits set: per-game enable mask, NGAMES bits.
REQ-005 SHALL have parameter NST, default 4: debug status channels, 1..4.
REQ-006 SHALL use one clock, clk; reset rst is synchronous and active-high.
REQ-007 SHALL have ports, in order:
- clk  in  1  system clock.
- rst  in  1  sync reset, active-high.
- prog_addr  in  log2(HDR_BYTES)  header byte offset.
- prog_data  in  8  download byte.
- prog_we  in  1  byte write strobe.
- header  in  1  current write targets the header.
- ioctl_rom  in  1  ROM download active.
- st_in  in  8*NST  packed debug status bytes; channel k = st_in[8k+7:8k].
- debug_bus  in  8  debug selector.
- game_id  out  IDW  decoded game id.
- game_sel  out  NGAMES  one-hot game flags.
- cfg_valid  out  1  configuration accepted.
- cfg_err  out  1  configuration rejected.
- debug_view  out  8  selected status byte.

Function
REQ-008 SHALL capture prog_data into header byte register prog_addr on every cycle where prog_we and header are both 1; the last write wins.
REQ-009 SHALL implement states IDLE, LOAD, CHECK, VALID, ERR.
REQ-010 SHALL transition IDLE->LOAD, VALID->LOAD and ERR->LOAD on a rising edge of ioctl_rom.
REQ-011 SHALL transition LOAD->CHECK on a falling edge of ioctl_rom; CHECK SHALL last exactly one cycle.
REQ-012 SHALL, in CHECK, go to VALID when all of the following hold; otherwise it SHALL go to ERR:
- XOR of all HDR_BYTES header bytes equals 0x00.
- id = byte[HDR_BYTES-1][IDW-1:0] is below NGAMES.
- ALLOW[id] = 1.
REQ-013 SHALL, on entry to VALID, set game_id = id, game_sel = 1<<id, cfg_valid=1 and cfg_err=0; these outputs SHALL be stable one cycle after CHECK.
REQ-014 SHALL, on entry to ERR, set game_id=0, game_sel=0, cfg_valid=0 and cfg_err=1.
REQ-015 SHALL hold game_id and game_sel at their previous values during LOAD, and SHALL drop cfg_valid and cfg_err to 0 on the cycle LOAD is entered.
REQ-016 SHALL ignore header writes while not in LOAD.
REQ-017 SHALL treat a rising edge of ioctl_rom during CHECK as taking effect after CHECK completes, so that it then moves VALID/ERR->LOAD.
REQ-018 SHALL register debug_view with one-cycle latency: sel = debug_bus[7:6]; debug_view = st channel sel if sel < NST, else 0x00.
REQ-019 SHALL keep game_sel one-hot or all-zero at all times.

Reset
REQ-020 SHALL, while rst=1, set state=IDLE, game_id=0, game_sel=0, cfg_valid=0, cfg_err=0, debug_view=0 and all header bytes=0.
REQ-021 SHALL treat rst asserted mid-LOAD or mid-CHECK as an abort: return to IDLE with no outputs updated from the partial header.
REQ-022 SHALL release from reset into IDLE even if ioctl_rom is already 1; a later falling edge while in IDLE SHALL be ignored.

Structure
REQ-023 SHALL place the state enumeration and the game-id constants (SSRIDERS=0, TMNT2=1, XMEN=2) in shared package jtriders_pkg.
REQ-024 SHALL implement the debug multiplexer as a single sub-module, jtriders_dbgmux.
REQ-025 SHALL update the checksum incrementally in LOAD; CHECK SHALL perform comparison only.

Verification
REQ-026 SHALL cover: header bytes with XOR 0 and byte15=0x02, then ioctl_rom falls -> two cycles later game_sel=3'b100, game_id=2, cfg_valid=1.
REQ-027 SHALL cover: ALLOW=3'b011 with header id=2 -> cfg_err=1, game_sel=0, game_id=0.
REQ-028 SHALL cover: byte3 corrupted (XOR=0x5A) -> cfg_err=1; a re-download with a correct header -> cfg_valid=1 and cfg_err=0.
REQ-029 SHALL cover: VALID with id=1, then a new download starts -> game_sel stays 3'b010 throughout LOAD while cfg_valid=0.
REQ-030 SHALL cover: rst pulsed mid-LOAD -> IDLE with all outputs 0; the following ioctl_rom fall does not assert cfg_valid.
REQ-031 SHALL cover: NST=2, debug_bus=8'h40 -> debug_view=st_in[15:8] next cycle; debug_bus=8'hC0 -> 0x00.

Source files
------------

// File: rtl/jtriders_pkg.sv
// jtriders_pkg: shared header-config FSM states and game-id constants (SSRIDERS, TMNT2, XMEN)
package jtriders_pkg;
  typedef enum logic [2:0] {IDLE, LOAD, CHECK, VALID, ERR} state_t;
  localparam int SSRIDERS = 0;
  localparam int TMNT2 = 1;
  localparam int XMEN = 2;
endpackage

// File: rtl/jtriders_dbgmux.sv
// jtriders_dbgmux: registered status-byte selector; in clk, rst, st_in (NST packed bytes), debug_bus (channel in [7:6]); out debug_view
module jtriders_dbgmux #(
  parameter int NST = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [8*NST-1:0] st_in,
  input  logic [7:0]     debug_bus,
  output logic [7:0]     debug_view
);
  logic [31:0] st_ext;
  logic unused_dbg;
  assign st_ext = 32'(st_in);
  assign unused_dbg = ^debug_bus[5:0];
  always_ff @(posedge clk) debug_view <= rst ? 8'h00 : st_ext[{debug_bus[7:6], 3'b000} +: 8];
endmodule

// File: rtl/jtriders_hdrcfg.sv
// jtriders_hdrcfg: ROM-header capture and validation; in prog_addr/prog_data/prog_we/header/ioctl_rom/st_in/debug_bus; out game_id, game_sel, cfg_valid, cfg_err, debug_view
module jtriders_hdrcfg
  import jtriders_pkg::*;
#(
  parameter int HDR_BYTES = 16,
  parameter int NGAMES = 3,
  parameter int IDW = 3,
  parameter logic [NGAMES-1:0] ALLOW = '1,
  parameter int NST = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [$clog2(HDR_BYTES)-1:0] prog_addr,
  input  logic [7:0]                   prog_data,
  input  logic                         prog_we,
  input  logic                         header,
  input  logic                         ioctl_rom,
  input  logic [8*NST-1:0]             st_in,
  input  logic [7:0]                   debug_bus,
  output logic [IDW-1:0]               game_id,
  output logic [NGAMES-1:0]            game_sel,
  output logic                         cfg_valid,
  output logic                         cfg_err,
  output logic [7:0]                   debug_view
);
  state_t state, nxt;
  logic [7:0] hdr [HDR_BYTES];
  logic [7:0] csum;
  logic rom_q, pend, rise, fall, wr, ok;
  logic [IDW-1:0] id, nxt_id;
  logic [NGAMES-1:0] allow_sh, nxt_sel;
  logic nxt_valid, nxt_err;
  assign rise = ioctl_rom & ~rom_q;
  assign fall = ~ioctl_rom & rom_q;
  assign wr = prog_we & header & (state == LOAD);
  assign id = hdr[HDR_BYTES-1][IDW-1:0];
  assign allow_sh = ALLOW >> id;
  assign ok = (csum == 8'h00) & (32'(id) < NGAMES) & allow_sh[0];
  always_ff @(posedge clk) begin
    rom_q <= ioctl_rom;
    if (rst) begin
      state <= IDLE;
      pend <= 1'b0;
      csum <= 8'h00;
      game_id <= '0;
      game_sel <= '0;
      cfg_valid <= 1'b0;
      cfg_err <= 1'b0;
      for (int i = 0; i < HDR_BYTES; i++) hdr[i] <= 8'h00;
    end else begin
      state <= nxt;
      pend <= (state == CHECK) & rise;
      game_id <= nxt_id;
      game_sel <= nxt_sel;
      cfg_valid <= nxt_valid;
      cfg_err <= nxt_err;
      if (wr) begin
        hdr[prog_addr] <= prog_data;
        csum <= csum ^ hdr[prog_addr] ^ prog_data;
      end
    end
  end
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = rise ? LOAD : IDLE;
      LOAD:    nxt = fall ? CHECK : LOAD;
      CHECK:   nxt = ok ? VALID : ERR;
      default: nxt = (rise | pend) ? LOAD : state;
    endcase
  end
  always_comb begin
    nxt_id = game_id;
    nxt_sel = game_sel;
    nxt_valid = cfg_valid;
    nxt_err = cfg_err;
    if (nxt == LOAD && state != LOAD) begin
      nxt_valid = 1'b0;
      nxt_err = 1'b0;
    end else if (state == CHECK) begin
      nxt_id = ok ? id : '0;
      nxt_sel = ok ? (NGAMES'(1) << id) : '0;
      nxt_valid = ok;
      nxt_err = ~ok;
    end
  end
  jtriders_dbgmux #(.NST(NST)) u_dbg (
    .clk(clk),
    .rst(rst),
    .st_in(st_in),
    .debug_bus(debug_bus),
    .debug_view(debug_view)
  );
endmodule

// File: tb/tb_jtriders_hdrcfg.sv
// tb_jtriders_hdrcfg: randomized scoreboard bench for jtriders_hdrcfg against a header-rule reference model
module tb_jtriders_hdrcfg;
  logic clk = 1'b0, rst = 1'b1;
  logic [3:0] prog_addr = '0;
  logic [7:0] prog_data = '0, debug_bus = '0;
  logic prog_we = 1'b0, header = 1'b0, ioctl_rom = 1'b0;
  logic [31:0] st_a = '0;
  logic [2:0] id_a, sel_a, id_b, sel_b;
  logic v_a, e_a, v_b, e_b;
  logic [7:0] dv_a, dv_b;
  always #5 clk = ~clk;
  jtriders_hdrcfg dut_a (
    .clk(clk), .rst(rst), .prog_addr(prog_addr), .prog_data(prog_data), .prog_we(prog_we),
    .header(header), .ioctl_rom(ioctl_rom), .st_in(st_a), .debug_bus(debug_bus),
    .game_id(id_a), .game_sel(sel_a), .cfg_valid(v_a), .cfg_err(e_a), .debug_view(dv_a)
  );
  jtriders_hdrcfg #(.ALLOW(3'b011), .NST(2)) dut_b (
    .clk(clk), .rst(rst), .prog_addr(prog_addr), .prog_data(prog_data), .prog_we(prog_we),
    .header(header), .ioctl_rom(ioctl_rom), .st_in(st_a[15:0]), .debug_bus(debug_bus),
    .game_id(id_b), .game_sel(sel_b), .cfg_valid(v_b), .cfg_err(e_b), .debug_view(dv_b)
  );
  typedef struct packed {logic [2:0] id; logic [2:0] sel; logic valid; logic err;} res_t;
  res_t q_a[$], q_b[$];
  res_t cur_a, cur_b, exp_r;
  logic [7:0] hm [16];
  logic [7:0] hb [16];
  int errors = 0, checks = 0;
  bit pres_a, pres_b, loading;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask
  function automatic res_t model(input bit [2:0] allow);
    logic [7:0] x;
    int g;
    x = 8'h00;
    for (int i = 0; i < 16; i++) x ^= hm[i];
    g = int'(hm[15][2:0]);
    if (x == 8'h00 && g < 3 && allow[g]) return '{id: 3'(g), sel: 3'(1 << g), valid: 1'b1, err: 1'b0};
    return '{id: 3'd0, sel: 3'd0, valid: 1'b0, err: 1'b1};
  endfunction
  always @(negedge clk) begin
    if (!rst) begin
      if ((v_a | e_a) && !pres_a) begin
        if (q_a.size() == 0) begin
          checks++; errors++;
          $display("FAIL a_unexpected_result: got %0h expected none", {id_a, sel_a, v_a, e_a});
        end else begin
          exp_r = q_a.pop_front();
          chk("a_result", {id_a, sel_a, v_a, e_a}, exp_r);
        end
      end
      if ((v_b | e_b) && !pres_b) begin
        if (q_b.size() == 0) begin
          checks++; errors++;
          $display("FAIL b_unexpected_result: got %0h expected none", {id_b, sel_b, v_b, e_b});
        end else begin
          exp_r = q_b.pop_front();
          chk("b_result", {id_b, sel_b, v_b, e_b}, exp_r);
        end
      end
      chk("onehot_sel", {$onehot0(sel_a), $onehot0(sel_b)}, 2'b11);
    end
    pres_a = v_a | e_a;
    pres_b = v_b | e_b;
  end
  task automatic load_chk();
    chk("a_load_hold", {id_a, sel_a, v_a, e_a}, {cur_a.id, cur_a.sel, 2'b00});
    chk("b_load_hold", {id_b, sel_b, v_b, e_b}, {cur_b.id, cur_b.sel, 2'b00});
  endtask
  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    foreach (hm[i]) hm[i] = 8'h00;
    cur_a = '0; cur_b = '0; loading = 1'b0;
    q_a.delete(); q_b.delete();
  endtask
  task automatic wr(input logic [3:0] a, input logic [7:0] d, input bit hflag, input bit in_load);
    prog_addr = a; prog_data = d; prog_we = 1'b1; header = hflag;
    @(negedge clk);
    prog_we = 1'b0; header = 1'b0;
    if (hflag && in_load) hm[a] = d;
    if (in_load) load_chk();
  endtask
  task automatic start_dl();
    ioctl_rom = 1'b1;
    @(negedge clk);
    load_chk();
  endtask
  task automatic end_dl(input bit restart);
    ioctl_rom = 1'b0;
    cur_a = model(3'b111);
    cur_b = model(3'b011);
    q_a.push_back(cur_a);
    q_b.push_back(cur_b);
    @(negedge clk);
    if (restart) ioctl_rom = 1'b1;
    @(negedge clk);
    #1;
    chk("result_latency_pending", q_a.size() + q_b.size(), 0);
    if (restart) begin
      @(negedge clk);
      load_chk();
    end
    loading = restart;
  endtask
  task automatic send(input bit restart);
    if (!loading) start_dl();
    wr(4'($urandom), 8'($urandom), 1'b1, 1'b1);
    wr(4'($urandom), 8'($urandom), 1'b0, 1'b1);
    for (int i = 0; i < 16; i++) wr(4'(i), hb[i], 1'b1, 1'b1);
    end_dl(restart);
  endtask
  initial begin
    logic [7:0] x, dsel [4];
    int mode, si;
    do_reset();
    chk("a_reset", {id_a, sel_a, v_a, e_a, dv_a}, 0);
    chk("b_reset", {id_b, sel_b, v_b, e_b, dv_b}, 0);
    foreach (hb[i]) hb[i] = 8'h00;
    hb[15] = 8'h02; hb[0] = 8'h02;
    send(1'b0);
    chk("a_id2_valid", {id_a, sel_a, v_a, e_a}, {3'd2, 3'b100, 2'b10});
    chk("b_id2_denied", {id_b, sel_b, v_b, e_b}, {3'd0, 3'b000, 2'b01});
    foreach (hb[i]) hb[i] = 8'h00;
    hb[15] = 8'h01; hb[0] = 8'h01; hb[3] = 8'h5A;
    send(1'b0);
    chk("a_bad_xor", {v_a, e_a, sel_a}, {2'b01, 3'b000});
    hb[3] = 8'h00;
    send(1'b0);
    chk("a_redownload_ok", {id_a, sel_a, v_a, e_a}, {3'd1, 3'b010, 2'b10});
    send(1'b1);
    hb[15] = 8'h00; hb[0] = 8'h00;
    send(1'b0);
    wr(4'hF, 8'h07, 1'b1, 1'b0);
    start_dl();
    end_dl(1'b0);
    chk("a_write_outside_load_ignored", {id_a, v_a, e_a}, {3'd0, 2'b10});
    start_dl();
    wr(4'h0, 8'h11, 1'b1, 1'b1);
    wr(4'hF, 8'h11, 1'b1, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    foreach (hm[i]) hm[i] = 8'h00;
    cur_a = '0; cur_b = '0;
    chk("a_abort_outputs", {id_a, sel_a, v_a, e_a}, 0);
    chk("b_abort_outputs", {id_b, sel_b, v_b, e_b}, 0);
    @(negedge clk);
    ioctl_rom = 1'b0;
    repeat (4) @(negedge clk);
    chk("a_idle_fall_ignored", {v_a, e_a, v_b, e_b}, 0);
    for (int n = 0; n < 30; n++) begin
      mode = $urandom_range(0, 3);
      foreach (hb[i]) hb[i] = 8'($urandom);
      if ($urandom_range(0, 1) == 1) hb[15][2:0] = 3'($urandom_range(0, 2));
      x = 8'h00;
      foreach (hb[i]) x ^= hb[i];
      if (mode != 0) hb[0] ^= x;
      if (!loading && $urandom_range(0, 3) == 0) wr(4'($urandom), 8'($urandom), 1'b1, 1'b0);
      send(mode == 3);
    end
    if (loading) send(1'b0);
    dsel[0] = 8'h40; dsel[1] = 8'hC0; dsel[2] = 8'h80; dsel[3] = 8'h00;
    for (int n = 0; n < 16; n++) begin
      st_a = $urandom;
      debug_bus = (n < 4) ? dsel[n] : 8'($urandom);
      si = int'(debug_bus[7:6]);
      @(negedge clk);
      chk("a_debug_view", dv_a, st_a[8*si +: 8]);
      chk("b_debug_view", dv_b, si < 2 ? st_a[8*si +: 8] : 8'h00);
    end
    chk("scoreboard_drained", q_a.size() + q_b.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
